// File: rtl/clk_enable_tracker_pkg.sv
// clk_enable_tracker_pkg: shared state encodings and widths for enable-related blocks.
// Ports: none (package only).
// Encodings are fixed so that future enable-related blocks decode the same values.
package clk_enable_tracker_pkg;

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // Good-period counter width; LOCK_COUNT is limited to 1..15.
  localparam int GOOD_W = 4;

endpackage

// File: rtl/clk_enable_tracker_period.sv
// ce_period_meter: measures cycles since the last clk_en_in strobe and classifies it.
// Ports: clk_base/rst in; clk_en_in in; good_strobe/early_strobe/timeout out (combinational).
// The flags are combinational from mctr_q and clk_en_in; the caller registers the results.
module ce_period_meter #(
  parameter int DIVIDE = 2
) (
  input  logic clk_base,
  input  logic rst,
  input  logic clk_en_in,
  output logic good_strobe,
  output logic early_strobe,
  output logic timeout
);

  localparam int MW = $clog2(DIVIDE) + 1;
  localparam logic [MW-1:0] MCTR_LAST = MW'(DIVIDE - 1);

  logic [MW-1:0] mctr_q;
  logic [MW-1:0] mctr_d;

  // mctr may run past MCTR_LAST only while the tracker is in SEARCH, where it
  // is ignored, so a free-running wrap is harmless.
  always_comb begin
    mctr_d = clk_en_in ? '0 : mctr_q + MW'(1);
  end

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) mctr_q <= '0;
    else     mctr_q <= mctr_d;
  end

  // A strobe always wins over a timeout.
  assign good_strobe  = clk_en_in && (mctr_q == MCTR_LAST);
  assign early_strobe = clk_en_in && (mctr_q <  MCTR_LAST);
  assign timeout      = !clk_en_in && (mctr_q == MCTR_LAST);

endmodule

// File: rtl/clk_enable_tracker.sv
// clk_enable_tracker: locks to an incoming clk_en strobe of period DIVIDE and regenerates it.
// Ports: clk_base, rst (async, active-high), clk_en_in -> clk_en_out, phase, locked, period_err[, err_count].
// All outputs registered, 1-cycle latency. Optional macro CLK_ENABLE_TRACKER_ERRCNT_EN adds err_count.
module clk_enable_tracker
  import clk_enable_tracker_pkg::*;
#(
  parameter int DIVIDE     = 2,
  parameter int LOCK_COUNT = 4
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
  ,parameter int ERR_CNT_W = 16
`endif
) (
  input  logic                      clk_base,
  input  logic                      rst,
  input  logic                      clk_en_in,
  output logic                      clk_en_out,
  output logic [$clog2(DIVIDE)-1:0] phase,
  output logic                      locked,
  output logic                      period_err
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
  ,output logic [ERR_CNT_W-1:0]     err_count
`endif
);

  localparam int PW = $clog2(DIVIDE);
  localparam logic [PW-1:0]     PHASE_LAST = PW'(DIVIDE - 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_COUNT);

  logic good_strobe;
  logic early_strobe;
  logic timeout;

  ce_period_meter #(.DIVIDE(DIVIDE)) u_meter (
    .clk_base     (clk_base),
    .rst          (rst),
    .clk_en_in    (clk_en_in),
    .good_strobe  (good_strobe),
    .early_strobe (early_strobe),
    .timeout      (timeout)
  );

  logic [1:0]        state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              locked_q, locked_d;
  logic              clk_en_out_q, clk_en_out_d;
  logic              period_err_q, period_err_d;

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    period_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        // Period is unknown here, so nothing can be an error.
        if (clk_en_in) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (good_strobe) begin
          good_d = good_q + GOOD_W'(1);
          if (good_q + GOOD_W'(1) == GOOD_LOCK) state_d = LOCKED;
        end else if (early_strobe) begin
          period_err_d = 1'b1;
          good_d       = '0;
        end else if (timeout) begin
          period_err_d = 1'b1;
          good_d       = '0;
          state_d      = SEARCH;
        end
      end
      LOCKED: begin
        // An early strobe still restarts the measurement in the meter, so
        // ACQUIRE begins counting from that strobe.
        if (early_strobe) begin
          period_err_d = 1'b1;
          good_d       = '0;
          state_d      = ACQUIRE;
        end else if (timeout) begin
          period_err_d = 1'b1;
          good_d       = '0;
          state_d      = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase

    // Outputs are computed from the next state so that they appear one cycle
    // after the strobe that caused the transition.
    locked_d     = (state_d == LOCKED);
    clk_en_out_d = clk_en_in && (state_d == LOCKED);
    if (state_d != LOCKED || clk_en_in) phase_d = '0;
    else if (phase_q == PHASE_LAST)     phase_d = '0;
    else                                phase_d = phase_q + PW'(1);
  end

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      good_q       <= '0;
      phase_q      <= '0;
      locked_q     <= 1'b0;
      clk_en_out_q <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      clk_en_out_q <= clk_en_out_d;
      period_err_q <= period_err_d;
    end
  end

  assign clk_en_out = clk_en_out_q;
  assign phase      = phase_q;
  assign locked     = locked_q;
  assign period_err = period_err_q;

`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Saturating: once all-ones it holds until reset.
  always_comb begin
    err_count_d = err_count_q;
    if (period_err_d && (err_count_q != {ERR_CNT_W{1'b1}}))
      err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  // Error counter not built; period_err is the only error indication.
`endif

endmodule

// File: tb/tb_clk_enable_tracker.sv
module tb_clk_enable_tracker;

  logic       clk_base = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic       ceo_a, ceo_b, lk_a, lk_b, pe_a, pe_b;
  logic [2:0] ph_a;
  logic [0:0] ph_b;
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
  logic [15:0] ec_a;
  logic [1:0]  ec_b;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_base = ~clk_base;

  clk_enable_tracker #(
    .DIVIDE(5), .LOCK_COUNT(4)
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
    ,.ERR_CNT_W(16)
`endif
  ) u_dut_a (
    .clk_base   (clk_base),
    .rst        (rst_a),
    .clk_en_in  (en_a),
    .clk_en_out (ceo_a),
    .phase      (ph_a),
    .locked     (lk_a),
    .period_err (pe_a)
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
    ,.err_count (ec_a)
`endif
  );

  clk_enable_tracker #(
    .DIVIDE(2), .LOCK_COUNT(1)
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
    ,.ERR_CNT_W(2)
`endif
  ) u_dut_b (
    .clk_base   (clk_base),
    .rst        (rst_b),
    .clk_en_in  (en_b),
    .clk_en_out (ceo_b),
    .phase      (ph_b),
    .locked     (lk_b),
    .period_err (pe_b)
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
    ,.err_count (ec_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // DUT A strobes: steady 10..35, early at 38, steady 43..68, 73 missing,
  // then steady 78..128 (103 falls inside reset).
  function automatic logic strobe_a(input int n);
    return (n >= 10 && n <= 35 && n % 5 == 0) || (n == 38) ||
           (n >= 43 && n <= 68 && (n - 43) % 5 == 0) ||
           (n >= 78 && n <= 128 && (n - 78) % 5 == 0);
  endfunction

  // DUT B strobes: every other cycle 20..40, then back-to-back 50..55.
  function automatic logic strobe_b(input int n);
    return (n >= 20 && n <= 40 && n % 2 == 0) || (n >= 50 && n <= 55);
  endfunction

  initial begin
    while (cyc < 140) begin
      @(posedge clk_base);
      #1;
      cyc++;
      en_a  = strobe_a(cyc);
      en_b  = strobe_b(cyc);
      rst_a = (cyc < 2) || (cyc == 103);
      rst_b = (cyc < 2) || (cyc == 60);

      case (cyc)
        1: begin
          chk("rst_locked_a", 32'(lk_a), 0);
          chk("rst_ceo_a", 32'(ceo_a), 0);
          chk("rst_phase_a", 32'(ph_a), 0);
          chk("rst_perr_a", 32'(pe_a), 0);
          chk("rst_locked_b", 32'(lk_b), 0);
        end
        11: chk("search_no_err_a", 32'(pe_a), 0);
        30: chk("prelock_a", 32'(lk_a), 0);
        31: begin
          chk("lock_a", 32'(lk_a), 1);
          chk("lock_ceo_a", 32'(ceo_a), 1);
          chk("lock_phase_a", 32'(ph_a), 0);
          chk("lock_perr_a", 32'(pe_a), 0);
        end
        32: chk("ceo_gap_a", 32'(ceo_a), 0);
        33: chk("phase2_a", 32'(ph_a), 2);
        35: chk("phase4_a", 32'(ph_a), 4);
        36: begin
          chk("ceo36_a", 32'(ceo_a), 1);
          chk("phase_wrap_a", 32'(ph_a), 0);
        end
        39: begin
          chk("early_perr_a", 32'(pe_a), 1);
          chk("early_unlock_a", 32'(lk_a), 0);
          chk("early_ceo_a", 32'(ceo_a), 0);
        end
        40: chk("perr_pulse_a", 32'(pe_a), 0);
        44: chk("acq_phase_a", 32'(ph_a), 0);
        58: chk("relock_pre_a", 32'(lk_a), 0);
        59: begin
          chk("relock_a", 32'(lk_a), 1);
          chk("relock_ceo_a", 32'(ceo_a), 1);
        end
        74: begin
          chk("timeout_perr_a", 32'(pe_a), 1);
          chk("timeout_unlock_a", 32'(lk_a), 0);
        end
        79: begin
          chk("search_ceo_a", 32'(ceo_a), 0);
          chk("search_perr_a", 32'(pe_a), 0);
        end
        98: chk("relock2_pre_a", 32'(lk_a), 0);
        99: chk("relock2_a", 32'(lk_a), 1);
        102: begin
          chk("phase3_a", 32'(ph_a), 3);
          #2 rst_a = 1'b1;
          #1;
          chk("async_rst_locked_a", 32'(lk_a), 0);
          chk("async_rst_phase_a", 32'(ph_a), 0);
          chk("async_rst_ceo_a", 32'(ceo_a), 0);
        end
        109: chk("post_rst_search_a", 32'(pe_a), 0);
        128: chk("rst_relock_pre_a", 32'(lk_a), 0);
        129: chk("rst_relock_a", 32'(lk_a), 1);
        22: chk("prelock_b", 32'(lk_b), 0);
        23: begin
          chk("lock_b", 32'(lk_b), 1);
          chk("lock_phase_b", 32'(ph_b), 0);
          chk("lock_ceo_b", 32'(ceo_b), 1);
        end
        24: begin
          chk("phase1_b", 32'(ph_b), 1);
          chk("ceo_gap_b", 32'(ceo_b), 0);
        end
        25: begin
          chk("phase_wrap_b", 32'(ph_b), 0);
          chk("ceo25_b", 32'(ceo_b), 1);
        end
        43: begin
          chk("timeout_perr_b", 32'(pe_b), 1);
          chk("timeout_unlock_b", 32'(lk_b), 0);
        end
        52: chk("early_perr_b", 32'(pe_b), 1);
`ifdef CLK_ENABLE_TRACKER_ERRCNT_EN
        56: chk("errcnt_sat_b", 32'(ec_b), 3);
        61: chk("errcnt_clr_b", 32'(ec_b), 0);
`endif
        default: ;
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
